sprite_painter: RTL and testbench



---
 rtl/sprite_painter.sv | 208 ++++++++++++++++++++
 tb/tb_sprite_painter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_painter.sv
// sprite_painter: per-frame back-buffer painter. Clears the draw buffer,
// then blits every non-empty render slot from the sprite-sheet ROM in
// ascending slot order. Transparent pixels are skipped and off-screen
// pixels are clipped. On completion it raises finished and flips draw_buf.
//
// ROM timing: rom_addr is a registered output. The sheet ROM returns the
// pixel for that address during the following cycle, and the write stage
// consumes it on the next edge.
module sprite_painter #(
    parameter int RENDER_SLOTS = 32,
    parameter int FB_W         = 1280,
    parameter int FB_H         = 300,
    parameter int SHEET_W      = 2446,
    parameter int ROM_AW       = 19,
    parameter int FB_AW        = 19
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [RENDER_SLOTS-1:0][47:0]  sprite,
    input  logic [RENDER_SLOTS-1:0][23:0]  pos,
    output logic [ROM_AW-1:0]              rom_addr,
    input  logic [1:0]                     rom_data,
    output logic                           fb_we,
    output logic [FB_AW-1:0]               fb_addr,
    output logic                           fb_data,
    output logic                           draw_buf,
    output logic                           finished,
    output logic                           busy
);

    localparam int SLOT_W = (RENDER_SLOTS > 1) ? $clog2(RENDER_SLOTS) : 1;
    localparam logic [SLOT_W-1:0]    SLOT_LAST = SLOT_W'(RENDER_SLOTS - 1);
    localparam logic [FB_AW-1:0]     CLR_LAST  = FB_AW'(FB_W * FB_H - 1);
    localparam logic signed [12:0]   FBW_S     = 13'(FB_W);
    localparam logic signed [12:0]   FBH_S     = 13'(FB_H);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FETCH,
        S_DRAW,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                 r_state;
    logic [FB_AW-1:0]       r_clr_addr;
    logic [SLOT_W-1:0]      r_slot;

    // Latched descriptor of the slot being drawn
    logic [11:0]            r_sx;
    logic [11:0]            r_sy;
    logic [11:0]            r_w;
    logic [11:0]            r_h;
    logic signed [11:0]     r_px;
    logic signed [11:0]     r_py;

    // Scan position inside the sprite
    logic [11:0]            r_col;
    logic [11:0]            r_row;

    // Destination travelling alongside the ROM request
    logic signed [12:0]     r_dx_p0;
    logic signed [12:0]     r_dy_p0;
    logic                   r_vld_p0;

    logic [47:0]            w_cur_spr;
    logic [23:0]            w_cur_pos;
    logic                   w_slot_empty;
    logic                   w_last_slot;
    logic signed [12:0]     w_dx;
    logic signed [12:0]     w_dy;
    logic [ROM_AW-1:0]      w_rom_lin;
    logic [FB_AW-1:0]       w_fb_lin;
    logic                   w_pix_wr;

    // True when a signed destination lies inside the framebuffer
    function automatic logic on_screen(input logic signed [12:0] dx,
                                       input logic signed [12:0] dy);
        return !dx[12] && (dx < FBW_S) && !dy[12] && (dy < FBH_S);
    endfunction

    assign w_cur_spr    = sprite[r_slot];
    assign w_cur_pos    = pos[r_slot];
    assign w_slot_empty = (w_cur_spr[23:12] == 12'd0) || (w_cur_spr[11:0] == 12'd0);
    assign w_last_slot  = (r_slot == SLOT_LAST);

    assign w_dx = 13'(r_px) + $signed({1'b0, r_col});
    assign w_dy = 13'(r_py) + $signed({1'b0, r_row});

    assign w_rom_lin = (ROM_AW'(r_sy) + ROM_AW'(r_row)) * ROM_AW'(SHEET_W)
                     + ROM_AW'(r_sx) + ROM_AW'(r_col);

    assign w_fb_lin  = FB_AW'($unsigned(r_dy_p0)) * FB_AW'(FB_W)
                     + FB_AW'($unsigned(r_dx_p0));

    assign w_pix_wr  = r_vld_p0 && rom_data[1] && on_screen(r_dx_p0, r_dy_p0);

    assign busy = (r_state != S_IDLE);

    // Frame sequencer: clear, slot fetch, sprite scan and ROM request stage
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_clr_addr <= '0;
            r_slot     <= '0;
            r_col      <= '0;
            r_row      <= '0;
            r_vld_p0   <= 1'b0;
            rom_addr   <= '0;
            draw_buf   <= 1'b0;
            finished   <= 1'b0;
        end else begin
            r_vld_p0 <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state    <= S_CLEAR;
                        r_clr_addr <= '0;
                        finished   <= 1'b0;
                    end
                end

                S_CLEAR: begin
                    r_clr_addr <= r_clr_addr + 1'b1;
                    if (r_clr_addr == CLR_LAST) begin
                        r_state <= S_FETCH;
                        r_slot  <= '0;
                    end
                end

                S_FETCH: begin
                    r_sx  <= w_cur_spr[47:36];
                    r_sy  <= w_cur_spr[35:24];
                    r_w   <= w_cur_spr[23:12];
                    r_h   <= w_cur_spr[11:0];
                    r_px  <= $signed(w_cur_pos[23:12]);
                    r_py  <= $signed(w_cur_pos[11:0]);
                    r_col <= '0;
                    r_row <= '0;
                    if (!w_slot_empty) begin
                        r_state <= S_DRAW;
                    end else if (w_last_slot) begin
                        r_state <= S_DONE;
                    end else begin
                        r_slot <= r_slot + 1'b1;
                    end
                end

                // Stage p0: ROM request and its destination leave together
                S_DRAW: begin
                    rom_addr <= w_rom_lin;
                    r_dx_p0  <= w_dx;
                    r_dy_p0  <= w_dy;
                    r_vld_p0 <= 1'b1;
                    if (r_col == r_w - 12'd1) begin
                        r_col <= '0;
                        if (r_row == r_h - 12'd1) begin
                            r_state <= S_DRAIN;
                        end else begin
                            r_row <= r_row + 12'd1;
                        end
                    end else begin
                        r_col <= r_col + 12'd1;
                    end
                end

                S_DRAIN: begin
                    if (w_last_slot) begin
                        r_state <= S_DONE;
                    end else begin
                        r_slot  <= r_slot + 1'b1;
                        r_state <= S_FETCH;
                    end
                end

                S_DONE: begin
                    draw_buf <= ~draw_buf;
                    finished <= 1'b1;
                    r_state  <= S_IDLE;
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Stage p1: framebuffer write port, fed by clear sweep or returned ROM pixel
    always_ff @(posedge clk) begin
        if (rst) begin
            fb_we   <= 1'b0;
            fb_addr <= '0;
            fb_data <= 1'b0;
        end else if (r_state == S_CLEAR) begin
            fb_we   <= 1'b1;
            fb_addr <= r_clr_addr;
            fb_data <= 1'b0;
        end else if (w_pix_wr) begin
            fb_we   <= 1'b1;
            fb_addr <= w_fb_lin;
            fb_data <= rom_data[0];
        end else begin
            fb_we   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sprite_painter.sv
// tb_sprite_painter: directed bench for sprite_painter on a 16x8 screen
// with an 8-pixel-wide sprite sheet and 32 render slots.
module tb_sprite_painter;

    localparam int NS   = 32;
    localparam int FW   = 16;
    localparam int FH   = 8;
    localparam int SW   = 8;
    localparam int RAW  = 19;
    localparam int FAW  = 19;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  start = 1'b0;
    logic [NS-1:0][47:0]   sprite;
    logic [NS-1:0][23:0]   pos;
    logic [RAW-1:0]        rom_addr;
    logic [1:0]            rom_data;
    logic                  fb_we;
    logic [FAW-1:0]        fb_addr;
    logic                  fb_data;
    logic                  draw_buf;
    logic                  finished;
    logic                  busy;

    int n_vec = 0;
    int n_err = 0;
    int rom_mode = 0;
    int busy_mid = 0;
    int wq_a[$];
    int wq_d[$];
    logic fbm [0:127];

    sprite_painter #(
        .RENDER_SLOTS(NS), .FB_W(FW), .FB_H(FH), .SHEET_W(SW),
        .ROM_AW(RAW), .FB_AW(FAW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .sprite(sprite), .pos(pos),
        .rom_addr(rom_addr), .rom_data(rom_data), .fb_we(fb_we),
        .fb_addr(fb_addr), .fb_data(fb_data), .draw_buf(draw_buf),
        .finished(finished), .busy(busy)
    );

    always #5 clk = ~clk;

    // Sheet image: mode 0 all opaque colour 1; mode 1 opaque on even
    // columns; mode 2 opaque with colour = row parity
    function automatic logic [1:0] rom_img(input logic [RAW-1:0] a, input int mode);
        int col;
        int row;
        col = int'(a) % SW;
        row = int'(a) / SW;
        case (mode)
            1:       return {(col % 2) == 0, 1'b1};
            2:       return {1'b1, (row % 2) == 1};
            default: return 2'b11;
        endcase
    endfunction

    assign rom_data = rom_img(rom_addr, rom_mode);

    always @(negedge clk) begin
        if (fb_we === 1'b1) begin
            wq_a.push_back(int'(fb_addr));
            wq_d.push_back(int'(fb_data));
            if (fb_addr < 128) fbm[fb_addr[6:0]] = fb_data;
        end
    end

    task automatic chk(input string tag, input int obs, input int want);
        n_vec++;
        assert (obs === want) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, want);
        end
    endtask

    function automatic int wa(input int i);
        return (i < wq_a.size()) ? wq_a[i] : -1;
    endfunction

    function automatic int wd(input int i);
        return (i < wq_d.size()) ? wq_d[i] : -1;
    endfunction

    task automatic clear_slots();
        for (int i = 0; i < NS; i++) begin
            sprite[i] = '0;
            pos[i]    = '0;
        end
    endtask

    task automatic set_slot(input int i, input int sx, input int sy, input int w,
                            input int h, input int px, input int py);
        sprite[i] = {12'(sx), 12'(sy), 12'(w), 12'(h)};
        pos[i]    = {12'(px), 12'(py)};
    endtask

    // Edges are counted from the edge just before the accepted start (=0)
    task automatic run_frame(input int poke_start, input int poke_rst, output int cyc);
        bit did_rst;
        did_rst = 1'b0;
        wq_a.delete();
        wq_d.delete();
        @(posedge clk);
        #1 start = 1'b1;
        cyc = 0;
        @(posedge clk);
        cyc = 1;
        #1 start = 1'b0;
        while (finished !== 1'b1 && !did_rst && cyc < 3000) begin
            if (cyc == poke_start) start = 1'b1;
            if (cyc == poke_rst) rst = 1'b1;
            @(posedge clk);
            cyc++;
            #1;
            start = 1'b0;
            if (cyc == 100) busy_mid = int'(busy);
            if (rst) begin
                rst = 1'b0;
                did_rst = 1'b1;
            end
        end
    endtask

    initial begin
        int cyc;
        int bad;
        int n0;
        int t2_a[8];
        t2_a = '{21, 22, 23, 24, 37, 38, 39, 40};

        clear_slots();
        for (int i = 0; i < 128; i++) fbm[i] = 1'bx;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_fb_we",    int'(fb_we), 0);
        chk("rst_fb_addr",  int'(fb_addr), 0);
        chk("rst_fb_data",  int'(fb_data), 0);
        chk("rst_rom_addr", int'(rom_addr), 0);
        chk("rst_draw_buf", int'(draw_buf), 0);
        chk("rst_finished", int'(finished), 0);
        chk("rst_busy",     int'(busy), 0);
        rst = 1'b0;

        // T1: all slots empty -> 128 clear writes, 32 fetches
        run_frame(-1, -1, cyc);
        chk("t1_cycles", cyc, 162);
        chk("t1_nwr", wq_a.size(), 128);
        bad = 0;
        for (int i = 0; i < 128; i++) if (wa(i) != i || wd(i) != 0) bad++;
        chk("t1_clear_bad", bad, 0);
        chk("t1_draw_buf", int'(draw_buf), 1);
        chk("t1_finished", int'(finished), 1);
        chk("t1_busy_mid", busy_mid, 1);
        chk("t1_busy_end", int'(busy), 0);

        // T2: slot 3 4x2 at (5,1), all opaque colour 1
        set_slot(3, 0, 0, 4, 2, 5, 1);
        rom_mode = 0;
        run_frame(-1, -1, cyc);
        chk("t2_cycles", cyc, 171);
        chk("t2_nwr", wq_a.size(), 136);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("t2_addr%0d", i), wa(128 + i), t2_a[i]);
            chk($sformatf("t2_data%0d", i), wd(128 + i), 1);
        end
        chk("t2_draw_buf", int'(draw_buf), 0);

        // T3: same slot at (-2,7): only (0,7),(1,7) survive clipping
        set_slot(3, 0, 0, 4, 2, -2, 7);
        run_frame(-1, -1, cyc);
        chk("t3_cycles", cyc, 171);
        chk("t3_nwr", wq_a.size(), 130);
        chk("t3_addr0", wa(128), 112);
        chk("t3_addr1", wa(129), 113);
        chk("t3_draw_buf", int'(draw_buf), 1);

        // T4: alternating opaque bit, 4x1 at (3,2) -> cols 0 and 2
        clear_slots();
        set_slot(0, 0, 0, 4, 1, 3, 2);
        rom_mode = 1;
        run_frame(-1, -1, cyc);
        chk("t4_cycles", cyc, 167);
        chk("t4_nwr", wq_a.size(), 130);
        chk("t4_addr0", wa(128), 35);
        chk("t4_addr1", wa(129), 37);
        chk("t4_draw_buf", int'(draw_buf), 0);

        // T5: slots 1 and 2 overlap at (2,3); sheet row 0 colour 0, row 1 colour 1
        clear_slots();
        set_slot(1, 0, 0, 3, 1, 2, 3);
        set_slot(2, 0, 1, 3, 1, 2, 3);
        rom_mode = 2;
        run_frame(-1, -1, cyc);
        chk("t5_cycles", cyc, 170);
        chk("t5_nwr", wq_a.size(), 134);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("t5_addr%0d", i), wa(128 + i), 50 + (i % 3));
            chk($sformatf("t5_data%0d", i), wd(128 + i), (i < 3) ? 0 : 1);
        end
        chk("t5_fb50", int'(fbm[50]), 1);
        chk("t5_fb52", int'(fbm[52]), 1);
        chk("t5_draw_buf", int'(draw_buf), 1);

        // T6: reset asserted mid-DRAW of slot 3
        clear_slots();
        set_slot(3, 0, 0, 4, 2, 5, 1);
        rom_mode = 0;
        run_frame(-1, 136, cyc);
        chk("t6_rst_cycle", cyc, 137);
        chk("t6_fb_we", int'(fb_we), 0);
        chk("t6_finished", int'(finished), 0);
        chk("t6_draw_buf", int'(draw_buf), 0);
        chk("t6_busy", int'(busy), 0);
        chk("t6_rom_addr", int'(rom_addr), 0);
        n0 = wq_a.size();
        repeat (4) @(posedge clk);
        #1;
        chk("t6_no_writes", wq_a.size() - n0, 0);
        chk("t6_still_idle", int'(busy), 0);

        // T7: following start paints a full frame normally
        run_frame(-1, -1, cyc);
        chk("t7_cycles", cyc, 171);
        chk("t7_nwr", wq_a.size(), 136);
        chk("t7_first_px", wa(128), 21);
        chk("t7_last_px", wa(135), 40);
        chk("t7_draw_buf", int'(draw_buf), 1);

        // T8: start pulsed during DRAW is ignored
        run_frame(136, -1, cyc);
        chk("t8_cycles", cyc, 171);
        chk("t8_nwr", wq_a.size(), 136);
        chk("t8_draw_buf", int'(draw_buf), 0);
        chk("t8_finished", int'(finished), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
